alu_issue_unit: RTL and testbench
=================================

Name: alu_issue_unit

Overview:
- Initiator side of the combinational ALU interface. It accepts register-form operation requests over a valid/ready handshake and reads two operands from an internal register file.
- It drives the ALU operand and op-code lines, captures the ALU result, and writes it back to the register file. A write-back event is reported to the control path.
- A host load port preloads registers. The ALU itself stays external; this block connects to its data_A, data_B, op_code and result ports.

Parameters:
- NREGS, 8, number of data registers; must be a power of 2 and at least 2.
- AW, $clog2(NREGS), register address width.
- DW, `DATA_BITS, data and op-code width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_op  in  DW  op code: one of `SUM `SUB `MULT `DIV `INC `DEC `AND `OR `XOR `COMP.
- req_rs1  in  AW  first source register.
- req_rs2  in  AW  second source register; ignored for unary ops.
- req_rd  in  AW  destination register.
- ld_en  in  1  host register load strobe.
- ld_addr  in  AW  host load address.
- ld_data  in  DW  host load data.
- alu_op  out  DW  to ALU op_code.
- alu_a  out  DW  to ALU data_A.
- alu_b  out  DW  to ALU data_B.
- alu_result  in  DW  from ALU result.
- wb_valid  out  1  one-cycle pulse: write-back performed.
- wb_rd  out  AW  write-back register.
- wb_data  out  DW  write-back value.
- err  out  1  one-cycle pulse: divide by zero, or op code not in the list above.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State IDLE; all registers 0.
  - req_ready=1. wb_valid, err and busy are 0.
  - alu_op, alu_a, alu_b, wb_rd and wb_data are 0.
- State machine: IDLE -> READ -> EXEC -> WB -> IDLE.
  - A request is accepted when req_valid && req_ready on a rising edge.
  - A write-back completes 3 cycles after acceptance.
  - Issue rate is at most one request per 4 cycles.
- IDLE:
  - req_ready=1.
  - On accept, latch op, rs1, rs2 and rd; go to READ.
- READ:
  - Latch regs[rs1] and regs[rs2].
  - Operand mapping:
    - Binary ops: alu_a = regs[rs2], alu_b = regs[rs1], so rd = rs1 OP rs2. SUB gives rs1 - rs2 and DIV gives rs1 / rs2.
    - Unary ops (`INC `DEC `COMP): alu_a = regs[rs1], alu_b = 0.
  - The operands are registered outputs, valid from the EXEC cycle onward.
- EXEC:
  - alu_op, alu_a and alu_b are stable; the ALU is combinational.
  - Capture alu_result into the write-back register; go to WB.
- WB:
  - Normal case: regs[rd] <= captured result; wb_valid=1; wb_rd and wb_data are valid this cycle.
  - Error case: op is `DIV with divisor 0, or op is unknown. No register write; wb_valid=0; err=1.
  - Go to IDLE. req_ready returns to 1 the next cycle.
- ALU outputs: alu_op, alu_a and alu_b hold their last values outside EXEC. They are not cleared.
- Host load:
  - Accepted in any state; regs[ld_addr] <= ld_data.
  - Same-cycle conflict with a WB write to the same register: the WB write wins and the load is dropped.
  - A load in the READ cycle to rs1 or rs2 is not seen; READ samples the pre-edge value.
- Widths:
  - All arithmetic is DW bits and wraps modulo 2^DW.
  - MULT keeps the low DW bits.
  - The unit does no arithmetic itself; results come only from alu_result.
- rs1 == rs2 == rd is legal. The same value feeds both operands and rd is overwritten in WB.
- req_* inputs are ignored outside IDLE.
- rst_n asserted mid-operation aborts immediately:
  - Any pending write-back is lost.
  - No wb_valid or err pulse is produced.
  - The register file clears.

Decomposition:
- Shared package (existing defines file): `DATA_BITS and the op-code macros.
- Add a state enum typedef st_e {IDLE, READ, EXEC, WB} to the shared package.
- Add a helper function is_unary(op) to the shared package.
- Natural sub-module: alu_regfile.
  - NREGS x DW storage with async reset.
  - Two combinational read ports.
  - One write port with the WB-over-load priority mux inside.

Test Plan:
- Load r1=7, r2=3. Request SUB, rd=r3 -> wb_valid 3 cycles after accept; wb_rd=3; wb_data=4; r3=4. req_ready low for 3 cycles.
- Load r1=0xFF..FF. Request INC on r1, rd=r1 -> wb_data=0 (wrap). Then COMP on r1 -> all-ones.
- Load r1=9, r2=0. Request DIV, rd=r4 -> err pulse in the WB cycle; wb_valid=0; r4 is unchanged.
- Same cycle as WB to r5: ld_en to r5 with 0xAA -> r5 holds the ALU result, not 0xAA.
- Assert rst_n=0 during EXEC of a MULT -> outputs return to reset values at once. No wb_valid appears after release; all registers read 0.
- Hold req_valid high continuously with 4 back-to-back requests -> exactly one accept per 4 cycles, and 4 wb_valid pulses in order.

Source files
------------

// File: rtl/alu_issue_unit_pkg.sv
// Shared definitions for the ALU issue unit: data width, op codes, FSM state
// type and op-code classification helpers.
`ifndef ALU_DEFINES
`define ALU_DEFINES
`define DATA_BITS 8
`define SUM  (`DATA_BITS'(0))
`define SUB  (`DATA_BITS'(1))
`define MULT (`DATA_BITS'(2))
`define DIV  (`DATA_BITS'(3))
`define INC  (`DATA_BITS'(4))
`define DEC  (`DATA_BITS'(5))
`define AND  (`DATA_BITS'(6))
`define OR   (`DATA_BITS'(7))
`define XOR  (`DATA_BITS'(8))
`define COMP (`DATA_BITS'(9))
`endif

package alu_issue_unit_pkg;

  localparam int unsigned DATA_W = `DATA_BITS;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} st_e;

  // Unary ops take their single operand from rs1 and feed zero on data_B.
  function automatic logic is_unary(input logic [DATA_W-1:0] op);
    return (op == `INC) || (op == `DEC) || (op == `COMP);
  endfunction

  // True for every op code the external ALU implements.
  function automatic logic is_known(input logic [DATA_W-1:0] op);
    case (op)
      `SUM, `SUB, `MULT, `DIV, `INC, `DEC, `AND, `OR, `XOR, `COMP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_unit_if.sv
// Request handshake between a requester (master) and the issue unit (slave).
interface alu_issue_unit_if #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] req_op;
  logic [AW-1:0] req_rs1;
  logic [AW-1:0] req_rs2;
  logic [AW-1:0] req_rd;

  modport master (output req_valid, req_op, req_rs1, req_rs2, req_rd,
                  input  req_ready);
  modport slave  (input  req_valid, req_op, req_rs1, req_rs2, req_rd,
                  output req_ready);
endinterface

// File: rtl/alu_issue_unit_regfile.sv
// NREGS x DW register file: two combinational read ports, one write port
// shared by host loads and write-backs (write-back has priority).
module alu_regfile #(
  parameter int unsigned NREGS = 8,
  parameter int unsigned AW    = $clog2(NREGS),
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data
);

  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];

  assign rdata1 = regs_q[raddr1];
  assign rdata2 = regs_q[raddr2];

  // Next-state: load first, then write-back overrides on an address clash.
  always_comb begin
    regs_d = regs_q;
    if (ld_en) regs_d[ld_addr] = ld_data;
    if (wb_en) regs_d[wb_addr] = wb_data;
  end

  // Storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue unit: accepts register-form ALU requests, reads operands, drives the
// external combinational ALU and writes the captured result back.
module alu_issue_unit
  import alu_issue_unit_pkg::*;
#(
  parameter int unsigned NREGS = 8,
  parameter int unsigned AW    = $clog2(NREGS),
  parameter int unsigned DW    = `DATA_BITS
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_issue_unit_if.slave req,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_result,
  output logic          wb_valid,
  output logic [AW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          err,
  output logic          busy
);

  st_e           st_q, st_d;
  logic [DW-1:0] op_q, op_d;
  logic [AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [DW-1:0] alu_op_q, alu_op_d, alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic          wb_valid_q, wb_valid_d, err_q, err_d;
  logic [AW-1:0] wb_rd_q, wb_rd_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic          req_ready_q, req_ready_d, busy_q, busy_d;
  logic [DW-1:0] rdata1, rdata2;
  logic          fault;

  alu_regfile #(.NREGS(NREGS), .AW(AW), .DW(DW)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr1  (rs1_q),
    .raddr2  (rs2_q),
    .rdata1  (rdata1),
    .rdata2  (rdata2),
    .wb_en   (wb_valid_q),
    .wb_addr (wb_rd_q),
    .wb_data (wb_data_q),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  // Divisor for DIV sits on data_A (rs2); unknown op codes also fault.
  assign fault = ((op_q == `DIV) && (alu_a_q == '0)) || !is_known(op_q);

  // FSM next-state and registered-output computation.
  always_comb begin
    st_d        = st_q;
    op_d        = op_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    wb_valid_d  = 1'b0;
    err_d       = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    req_ready_d = req_ready_q;
    busy_d      = busy_q;
    case (st_q)
      IDLE: begin
        if (req.req_valid && req_ready_q) begin
          op_d        = req.req_op;
          rs1_d       = req.req_rs1;
          rs2_d       = req.req_rs2;
          rd_d        = req.req_rd;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          st_d        = READ;
        end
      end
      READ: begin
        alu_op_d = op_q;
        if (is_unary(op_q)) begin
          alu_a_d = rdata1;
          alu_b_d = '0;
        end else begin
          alu_a_d = rdata2;
          alu_b_d = rdata1;
        end
        st_d = EXEC;
      end
      EXEC: begin
        if (fault) begin
          err_d = 1'b1;
        end else begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = alu_result;
        end
        st_d = WB;
      end
      WB: begin
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
        st_d        = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any pending write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= IDLE;
      op_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      wb_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      st_q        <= st_d;
      op_q        <= op_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      wb_valid_q  <= wb_valid_d;
      err_q       <= err_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign req.req_ready = req_ready_q;
  assign alu_op        = alu_op_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign err           = err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural model of the external ALU.
`ifndef ALU_DEFINES
`define ALU_DEFINES
`define DATA_BITS 8
`define SUM  (`DATA_BITS'(0))
`define SUB  (`DATA_BITS'(1))
`define MULT (`DATA_BITS'(2))
`define DIV  (`DATA_BITS'(3))
`define INC  (`DATA_BITS'(4))
`define DEC  (`DATA_BITS'(5))
`define AND  (`DATA_BITS'(6))
`define OR   (`DATA_BITS'(7))
`define XOR  (`DATA_BITS'(8))
`define COMP (`DATA_BITS'(9))
`endif

module tb_alu_issue_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ld_en;
  logic [2:0] ld_addr;
  logic [7:0] ld_data;
  logic [7:0] alu_op, alu_a, alu_b, alu_result;
  logic       wb_valid, err, busy;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;

  int n_checks = 0;
  int n_errors = 0;

  alu_issue_unit_if #(.AW(3), .DW(8)) req_if ();

  alu_issue_unit #(.NREGS(8), .AW(3), .DW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req_if),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .err        (err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // External ALU: result = data_B op data_A; unary ops use data_A.
  always_comb begin
    case (alu_op)
      `SUM:    alu_result = alu_b + alu_a;
      `SUB:    alu_result = alu_b - alu_a;
      `MULT:   alu_result = alu_b * alu_a;
      `DIV:    alu_result = (alu_a == 8'd0) ? 8'hFF : alu_b / alu_a;
      `INC:    alu_result = alu_a + 8'd1;
      `DEC:    alu_result = alu_a - 8'd1;
      `AND:    alu_result = alu_b & alu_a;
      `OR:     alu_result = alu_b | alu_a;
      `XOR:    alu_result = alu_b ^ alu_a;
      `COMP:   alu_result = ~alu_a;
      default: alu_result = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [2:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic set_req(input logic v, input logic [7:0] op, input logic [2:0] s1,
                         input logic [2:0] s2, input logic [2:0] d);
    req_if.req_valid = v; req_if.req_op = op;
    req_if.req_rs1 = s1; req_if.req_rs2 = s2; req_if.req_rd = d;
  endtask

  // One full request from IDLE; called at a negedge with the unit idle.
  task automatic run_op(input string tag, input logic [7:0] op, input logic [2:0] s1,
                        input logic [2:0] s2, input logic [2:0] d,
                        input logic [7:0] exp_a, input logic [7:0] exp_b,
                        input logic [7:0] exp_data, input bit exp_err, input bit ld_in_wb);
    check({tag, " ready_idle"}, req_if.req_ready, 1);
    set_req(1'b1, op, s1, s2, d);
    @(negedge clk);                       // READ
    set_req(1'b0, 8'h00, 3'd0, 3'd0, 3'd0);
    check({tag, " ready_read"}, req_if.req_ready, 0);
    check({tag, " busy_read"}, busy, 1);
    @(negedge clk);                       // EXEC
    check({tag, " ready_exec"}, req_if.req_ready, 0);
    check({tag, " alu_op"}, alu_op, op);
    check({tag, " alu_a"}, alu_a, exp_a);
    check({tag, " alu_b"}, alu_b, exp_b);
    check({tag, " wb_early"}, wb_valid, 0);
    @(negedge clk);                       // WB
    check({tag, " ready_wb"}, req_if.req_ready, 0);
    check({tag, " wb_valid"}, wb_valid, !exp_err);
    check({tag, " err"}, err, exp_err);
    if (!exp_err) begin
      check({tag, " wb_rd"}, wb_rd, d);
      check({tag, " wb_data"}, wb_data, exp_data);
    end
    if (ld_in_wb) begin
      ld_en = 1'b1; ld_addr = d; ld_data = 8'hAA;
    end
    @(negedge clk);                       // back to IDLE
    ld_en = 1'b0;
    check({tag, " wb_pulse_end"}, wb_valid, 0);
    check({tag, " err_pulse_end"}, err, 0);
    check({tag, " ready_back"}, req_if.req_ready, 1);
    check({tag, " busy_back"}, busy, 0);
  endtask

  logic [7:0] b2b_op   [4] = '{`SUM, `SUB, `AND, `OR};
  logic [2:0] b2b_rd   [4] = '{3'd4, 3'd5, 3'd6, 3'd7};
  logic [7:0] b2b_data [4] = '{8'd10, 8'd4, 8'd3, 8'd7};

  initial begin
    int acc_cyc [4];
    int wb_cyc  [4];
    logic [2:0] wb_rd_seen   [4];
    logic [7:0] wb_data_seen [4];
    int nacc, nwb, idx, pulses;
    bit acc_prev;

    rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    set_req(1'b0, 8'h00, 3'd0, 3'd0, 3'd0);
    repeat (2) @(negedge clk);
    check("rst req_ready", req_if.req_ready, 1);
    check("rst busy", busy, 0);
    check("rst wb_valid", wb_valid, 0);
    check("rst err", err, 0);
    check("rst alu_op", alu_op, 0);
    check("rst alu_a", alu_a, 0);
    check("rst alu_b", alu_b, 0);
    check("rst wb_rd", wb_rd, 0);
    check("rst wb_data", wb_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // SUB: r3 = 7 - 3
    load(3'd1, 8'd7); load(3'd2, 8'd3);
    run_op("sub", `SUB, 3'd1, 3'd2, 3'd3, 8'd3, 8'd7, 8'd4, 1'b0, 1'b0);
    check("sub r3", dut.u_rf.regs_q[3], 8'd4);

    // INC wrap on r1, then COMP
    load(3'd1, 8'hFF);
    run_op("inc", `INC, 3'd1, 3'd2, 3'd1, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0);
    check("inc r1", dut.u_rf.regs_q[1], 8'h00);
    run_op("comp", `COMP, 3'd1, 3'd2, 3'd1, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0);
    check("comp r1", dut.u_rf.regs_q[1], 8'hFF);

    // DEC wrap, MULT truncation
    load(3'd6, 8'h00);
    run_op("dec", `DEC, 3'd6, 3'd6, 3'd6, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0);
    load(3'd1, 8'h13); load(3'd2, 8'h11);
    run_op("mult", `MULT, 3'd1, 3'd2, 3'd3, 8'h11, 8'h13, 8'h43, 1'b0, 1'b0);
    // Same register everywhere: r2 = r2 ^ r2
    run_op("xor_self", `XOR, 3'd2, 3'd2, 3'd2, 8'h11, 8'h11, 8'h00, 1'b0, 1'b0);

    // DIV by zero and unknown op: err, r4 untouched
    load(3'd1, 8'd9); load(3'd2, 8'd0); load(3'd4, 8'h55);
    run_op("div0", `DIV, 3'd1, 3'd2, 3'd4, 8'd0, 8'd9, 8'h00, 1'b1, 1'b0);
    check("div0 r4", dut.u_rf.regs_q[4], 8'h55);
    run_op("badop", 8'd12, 3'd1, 3'd2, 3'd4, 8'd0, 8'd9, 8'h00, 1'b1, 1'b0);
    check("badop r4", dut.u_rf.regs_q[4], 8'h55);
    load(3'd2, 8'd3);
    run_op("div", `DIV, 3'd1, 3'd2, 3'd4, 8'd3, 8'd9, 8'd3, 1'b0, 1'b0);

    // Write-back wins over a same-cycle host load to rd
    run_op("clash", `SUM, 3'd1, 3'd2, 3'd5, 8'd3, 8'd9, 8'd12, 1'b0, 1'b1);
    check("clash r5", dut.u_rf.regs_q[5], 8'd12);

    // Reset during EXEC of a MULT
    load(3'd1, 8'd3); load(3'd2, 8'd5);
    set_req(1'b1, `MULT, 3'd1, 3'd2, 3'd6);
    @(negedge clk);
    set_req(1'b0, 8'h00, 3'd0, 3'd0, 3'd0);
    @(negedge clk);
    check("mid exec busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid rst busy", busy, 0);
    check("mid rst ready", req_if.req_ready, 1);
    check("mid rst alu_op", alu_op, 0);
    check("mid rst alu_a", alu_a, 0);
    check("mid rst alu_b", alu_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (wb_valid || err) pulses++;
    end
    check("mid rst no pulse", pulses, 0);
    for (int i = 0; i < 8; i++) check($sformatf("mid rst r%0d", i), dut.u_rf.regs_q[i], 0);

    // Back-to-back requests with req_valid held high
    load(3'd1, 8'd7); load(3'd2, 8'd3);
    for (int i = 0; i < 4; i++) begin
      acc_cyc[i] = -100; wb_cyc[i] = -100; wb_rd_seen[i] = '0; wb_data_seen[i] = '0;
    end
    nacc = 0; nwb = 0; idx = 0; acc_prev = 1'b0;
    set_req(1'b1, b2b_op[0], 3'd1, 3'd2, b2b_rd[0]);
    for (int cyc = 0; cyc < 40 && nwb < 4; cyc++) begin
      if (acc_prev) begin
        idx++;
        if (idx < 4) set_req(1'b1, b2b_op[idx], 3'd1, 3'd2, b2b_rd[idx]);
        else         set_req(1'b0, 8'h00, 3'd0, 3'd0, 3'd0);
      end
      if (wb_valid) begin
        if (nwb < 4) begin
          wb_cyc[nwb] = cyc; wb_rd_seen[nwb] = wb_rd; wb_data_seen[nwb] = wb_data;
        end
        nwb++;
      end
      acc_prev = req_if.req_valid && req_if.req_ready;
      if (acc_prev) begin
        if (nacc < 4) acc_cyc[nacc] = cyc;
        nacc++;
      end
      @(negedge clk);
    end
    set_req(1'b0, 8'h00, 3'd0, 3'd0, 3'd0);
    check("b2b accepts", nacc, 4);
    check("b2b wb count", nwb, 4);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) check($sformatf("b2b gap%0d", i), acc_cyc[i] - acc_cyc[i-1], 4);
      check($sformatf("b2b lat%0d", i), wb_cyc[i] - acc_cyc[i], 3);
      check($sformatf("b2b rd%0d", i), wb_rd_seen[i], b2b_rd[i]);
      check($sformatf("b2b data%0d", i), wb_data_seen[i], b2b_data[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
